// File: rtl/uart_apb_bridge_if.sv
// Register-bus signals between the UART debug bridge (sole master) and the IO-config register file.
`timescale 1ns/1ps
interface uart_apb_bridge_if;
   logic        o_penable;
   logic        o_pwrite;
   logic [31:0] o_paddr;
   logic [31:0] o_pwdata;
   logic        i_pready;
   logic [31:0] i_prdata;

   modport master (
      output o_penable, o_pwrite, o_paddr, o_pwdata,
      input  i_pready, i_prdata
   );

   modport slave (
      input  o_penable, o_pwrite, o_paddr, o_pwdata,
      output i_pready, i_prdata
   );
endinterface

// File: rtl/uart_apb_bridge.sv
// UART host command frames ('W'/'R' + address [+ data]) turned into single register-bus transfers,
// with 'K', read data or 'E' serialised back to the host.
`timescale 1ns/1ps
module uart_apb_bridge #(
   parameter int unsigned TimeoutCyc = 255
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [7:0]        c_baud_cyc,
   input  logic              i_uart_rx,
   output logic              o_uart_tx,
   uart_apb_bridge_if.master bus
);
   localparam int unsigned   TW    = $clog2(TimeoutCyc + 1);
   localparam logic [TW-1:0] TLAST = TW'(TimeoutCyc - 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [2:0] {S_CMD, S_ADDR, S_WDATA, S_BUS, S_RESP} state_t;

   rx_state_t     rx_state;
   logic          rx_s1, rx_s2, rx_d;
   logic [7:0]    rx_cnt, rx_sh, half_baud;
   logic [2:0]    rx_bit;
   logic          rx_valid, rx_ferr;

   state_t        state;
   logic [1:0]    byte_cnt;
   logic [TW-1:0] tcnt;
   logic          bus_done, bus_tmo;

   logic          tx_busy;
   logic [3:0]    tx_phase;
   logic [7:0]    tx_bcnt, tx_cur;
   logic [23:0]   tx_q;
   logic [2:0]    tx_left;

   always_comb begin
      half_baud = {1'b0, c_baud_cyc[7:1]};
      bus_done  = bus.o_penable & bus.i_pready;
      bus_tmo   = bus.o_penable & ~bus.i_pready & (tcnt == TLAST);
   end

   // Receiver: start only on a real falling edge so a stop=0 frame cannot retrigger itself.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rx_s1    <= 1'b1;
         rx_s2    <= 1'b1;
         rx_d     <= 1'b1;
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_sh    <= '0;
         rx_bit   <= '0;
         rx_valid <= 1'b0;
         rx_ferr  <= 1'b0;
      end else begin
         rx_s1    <= i_uart_rx;
         rx_s2    <= rx_s1;
         rx_d     <= rx_s2;
         rx_valid <= 1'b0;
         rx_ferr  <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               if (rx_d && !rx_s2) begin
                  rx_state <= RX_START;
                  rx_cnt   <= '0;
               end
            end
            RX_START: begin
               if (rx_cnt == half_baud) begin
                  rx_cnt   <= '0;
                  rx_bit   <= '0;
                  rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
               end else begin
                  rx_cnt <= rx_cnt + 8'd1;
               end
            end
            RX_DATA: begin
               if (rx_cnt == c_baud_cyc) begin
                  rx_cnt <= '0;
                  rx_sh  <= {rx_s2, rx_sh[7:1]};
                  rx_bit <= rx_bit + 3'd1;
                  if (rx_bit == 3'd7) rx_state <= RX_STOP;
               end else begin
                  rx_cnt <= rx_cnt + 8'd1;
               end
            end
            RX_STOP: begin
               if (rx_cnt == c_baud_cyc) begin
                  rx_cnt   <= '0;
                  rx_valid <= rx_s2;
                  rx_ferr  <= !rx_s2;
                  rx_state <= RX_IDLE;
               end else begin
                  rx_cnt <= rx_cnt + 8'd1;
               end
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state        <= S_CMD;
         byte_cnt     <= '0;
         tcnt         <= '0;
         bus.o_penable <= 1'b0;
         bus.o_pwrite  <= 1'b0;
         bus.o_paddr   <= '0;
         bus.o_pwdata  <= '0;
      end else begin
         case (state)
            S_CMD: begin
               if (rx_valid && (rx_sh == 8'h57 || rx_sh == 8'h52)) begin
                  bus.o_pwrite <= (rx_sh == 8'h57);
                  byte_cnt     <= '0;
                  state        <= S_ADDR;
               end
            end
            S_ADDR: begin
               if (rx_ferr) begin
                  state <= S_CMD;
               end else if (rx_valid) begin
                  bus.o_paddr <= {bus.o_paddr[23:0], rx_sh};
                  byte_cnt    <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) begin
                     byte_cnt <= '0;
                     if (bus.o_pwrite) begin
                        state <= S_WDATA;
                     end else begin
                        state         <= S_BUS;
                        bus.o_penable <= 1'b1;
                        tcnt          <= '0;
                     end
                  end
               end
            end
            S_WDATA: begin
               if (rx_ferr) begin
                  state <= S_CMD;
               end else if (rx_valid) begin
                  bus.o_pwdata <= {bus.o_pwdata[23:0], rx_sh};
                  byte_cnt     <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) begin
                     state         <= S_BUS;
                     bus.o_penable <= 1'b1;
                     tcnt          <= '0;
                  end
               end
            end
            S_BUS: begin
               if (bus_done || bus_tmo) begin
                  bus.o_penable <= 1'b0;
                  state         <= S_RESP;
               end else begin
                  tcnt <= tcnt + TW'(1);
               end
            end
            S_RESP: begin
               if (!tx_busy) state <= S_CMD;
            end
            default: state <= S_CMD;
         endcase
      end
   end

   // Transmitter loads straight from the completing bus cycle so the start bit follows immediately.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_uart_tx <= 1'b1;
         tx_busy   <= 1'b0;
         tx_phase  <= '0;
         tx_bcnt   <= '0;
         tx_cur    <= '0;
         tx_q      <= '0;
         tx_left   <= '0;
      end else if (bus_done || bus_tmo) begin
         tx_busy   <= 1'b1;
         tx_phase  <= '0;
         tx_bcnt   <= '0;
         o_uart_tx <= 1'b0;
         if (bus_tmo) begin
            tx_cur  <= 8'h45;
            tx_q    <= '0;
            tx_left <= 3'd1;
         end else if (bus.o_pwrite) begin
            tx_cur  <= 8'h4B;
            tx_q    <= '0;
            tx_left <= 3'd1;
         end else begin
            tx_cur  <= bus.i_prdata[31:24];
            tx_q    <= bus.i_prdata[23:0];
            tx_left <= 3'd4;
         end
      end else if (tx_busy) begin
         if (tx_bcnt == c_baud_cyc) begin
            tx_bcnt <= '0;
            if (tx_phase == 4'd9) begin
               if (tx_left > 3'd1) begin
                  tx_cur    <= tx_q[23:16];
                  tx_q      <= {tx_q[15:0], 8'h00};
                  tx_left   <= tx_left - 3'd1;
                  tx_phase  <= '0;
                  o_uart_tx <= 1'b0;
               end else begin
                  tx_busy   <= 1'b0;
                  tx_left   <= '0;
                  o_uart_tx <= 1'b1;
               end
            end else begin
               tx_phase <= tx_phase + 4'd1;
               if (tx_phase == 4'd8) begin
                  o_uart_tx <= 1'b1;
               end else begin
                  o_uart_tx <= tx_cur[0];
                  tx_cur    <= {1'b0, tx_cur[7:1]};
               end
            end
         end else begin
            tx_bcnt <= tx_bcnt + 8'd1;
         end
      end
   end
endmodule

// File: tb/tb_uart_apb_bridge.sv
// Bench for uart_apb_bridge: directed command table, reset/robustness sequences and
// randomized commands checked against a transaction-level model of host, slave and responses.
`timescale 1ns/1ps
module tb_uart_apb_bridge;
   localparam int unsigned TMO = 255;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] baud  = 8'd3;
   logic       rx    = 1'b1;
   logic       tx;

   uart_apb_bridge_if bus ();

   uart_apb_bridge #(.TimeoutCyc(TMO)) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .c_baud_cyc (baud),
      .i_uart_rx  (rx),
      .o_uart_tx  (tx),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        w;
      logic [31:0] a;
      logic [31:0] d;
   } xfer_t;

   xfer_t       xq[$];
   int unsigned lenq[$];
   logic [7:0]  rxq[$];
   int unsigned lat = 0;
   logic [31:0] slave_rdata = '0;
   int unsigned pcyc = 0;
   logic        prev_pen = 1'b0;
   xfer_t       mon_x;

   // Slave model: raises pready on penable cycle lat+1, logs completions and penable lengths.
   initial begin
      bus.i_pready = 1'b0;
      bus.i_prdata = '0;
      forever begin
         @(negedge clk);
         if (rst_n && bus.o_penable) begin
            bus.i_prdata = slave_rdata;
            bus.i_pready = (pcyc == lat);
            if (bus.i_pready) begin
               mon_x.w = bus.o_pwrite;
               mon_x.a = bus.o_paddr;
               mon_x.d = bus.o_pwdata;
               xq.push_back(mon_x);
            end
            pcyc++;
         end else begin
            bus.i_pready = 1'b0;
            if (prev_pen && rst_n) begin
               lenq.push_back(pcyc);
               chk("tx_start_after_bus", {31'd0, tx}, 32'd0);
            end
            pcyc = 0;
         end
         prev_pen = bus.o_penable;
      end
   end

   // Host-side UART receiver.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && tx === 1'b0) begin
            int unsigned p;
            logic [7:0]  b;
            p = int'(baud) + 1;
            repeat (p / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (p) @(negedge clk);
               b[i] = tx;
            end
            repeat (p) @(negedge clk);
            chk("tx_stop_bit", {31'd0, tx}, 32'd1);
            rxq.push_back(b);
         end
      end
   end

   int unsigned run_lo = 0;
   int unsigned min_lo = 32'hFFFF;
   initial begin
      forever begin
         @(negedge clk);
         if (tx === 1'b0) begin
            run_lo++;
         end else begin
            if (run_lo != 0 && run_lo < min_lo) min_lo = run_lo;
            run_lo = 0;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic send_byte(input logic [7:0] b, input logic stopb = 1'b1);
      int unsigned p;
      p  = int'(baud) + 1;
      rx = 1'b0;
      repeat (p) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (p) @(negedge clk);
      end
      rx = stopb;
      repeat (p) @(negedge clk);
      rx = 1'b1;
   endtask

   task automatic run_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input int unsigned l, input logic [31:0] rd);
      lat         = l;
      slave_rdata = rd;
      min_lo      = 32'hFFFF;
      send_byte(w ? 8'h57 : 8'h52);
      for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8]);
      if (w) for (int i = 3; i >= 0; i--) send_byte(d[8*i +: 8]);
   endtask

   task automatic check_result(input string name, input logic w, input logic [31:0] a,
                               input logic [31:0] d, input int unsigned ncomp,
                               input int unsigned len, input int unsigned nresp,
                               input logic [31:0] resp);
      int unsigned budget;
      int unsigned k;
      xfer_t       x;
      budget = (nresp + 1) * 10 * (int'(baud) + 1) + TMO + 600;
      k = 0;
      while (rxq.size() < nresp && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk({name, " resp_count"}, rxq.size(), nresp);
      chk({name, " n_xfer"}, lenq.size(), 1);
      if (lenq.size() > 0) chk({name, " pen_len"}, lenq.pop_front(), len);
      chk({name, " n_complete"}, xq.size(), ncomp);
      if (xq.size() > 0) begin
         x = xq.pop_front();
         chk({name, " pwrite"}, {31'd0, x.w}, {31'd0, w});
         chk({name, " paddr"}, x.a, a);
         if (x.w) chk({name, " pwdata"}, x.d, d);
      end
      for (int i = 0; i < int'(nresp); i++) begin
         if (rxq.size() > 0) chk({name, " resp_byte"}, {24'd0, rxq.pop_front()},
                                 {24'd0, resp[8*(int'(nresp)-1-i) +: 8]});
      end
      repeat (2 * (int'(baud) + 1)) @(negedge clk);
      xq.delete();
      lenq.delete();
      rxq.delete();
   endtask

   typedef struct {
      logic        w;
      logic [7:0]  bd;
      logic [31:0] a;
      logic [31:0] d;
      int unsigned l;
      logic [31:0] rd;
      int unsigned ncomp;
      int unsigned len;
      int unsigned nresp;
      logic [31:0] resp;
      int unsigned period;
   } vec_t;

   vec_t vt[6];

   initial begin
      int unsigned k;
      int unsigned p;
      logic        w;
      logic [31:0] a, d, rd;
      int unsigned l, elen, enr, ecomp;
      logic [31:0] eresp;

      vt[0] = '{1'b1, 8'd3,   32'h0000_2004, 32'h0000_012F, 0,    32'h0,         1, 1,   1, 32'h4B,        4};
      vt[1] = '{1'b0, 8'd3,   32'h0000_2004, 32'h0,         1,    32'h0000_012F, 1, 2,   4, 32'h0000_012F, 0};
      vt[2] = '{1'b0, 8'd3,   32'h0000_3000, 32'h0,         1000, 32'hDEAD_BEEF, 0, 255, 1, 32'h45,        4};
      vt[3] = '{1'b1, 8'd3,   32'h0000_0010, 32'hAABB_CCDD, 0,    32'h0,         1, 1,   1, 32'h4B,        4};
      vt[4] = '{1'b1, 8'd10,  32'h0000_2004, 32'h0000_012F, 0,    32'h0,         1, 1,   1, 32'h4B,        11};
      vt[5] = '{1'b1, 8'd255, 32'h0000_2004, 32'h0000_012F, 0,    32'h0,         1, 1,   1, 32'h4B,        256};

      repeat (3) @(negedge clk);
      #1;
      chk("reset tx", {31'd0, tx}, 32'd1);
      chk("reset penable", {31'd0, bus.o_penable}, 32'd0);
      chk("reset pwrite", {31'd0, bus.o_pwrite}, 32'd0);
      chk("reset paddr", bus.o_paddr, 32'd0);
      chk("reset pwdata", bus.o_pwdata, 32'd0);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);

      foreach (vt[i]) begin
         baud = vt[i].bd;
         repeat (5) @(negedge clk);
         run_cmd(vt[i].w, vt[i].a, vt[i].d, vt[i].l, vt[i].rd);
         check_result($sformatf("vec%0d", i), vt[i].w, vt[i].a, vt[i].d,
                      vt[i].ncomp, vt[i].len, vt[i].nresp, vt[i].resp);
         if (vt[i].period != 0) chk($sformatf("vec%0d bit_period", i), min_lo, vt[i].period);
      end

      // Noise byte, short glitch and an aborted command must produce nothing.
      baud = 8'd10;
      p    = 11;
      repeat (5) @(negedge clk);
      send_byte(8'hAA);
      rx = 1'b0;
      repeat (2) @(negedge clk);
      rx = 1'b1;
      repeat (40) @(negedge clk);
      send_byte(8'h57);
      send_byte(8'h00);
      send_byte(8'h11, 1'b0);
      repeat (30 * p) @(negedge clk);
      chk("robust n_xfer", lenq.size(), 0);
      chk("robust resp_count", rxq.size(), 0);
      run_cmd(1'b1, 32'h0000_0040, 32'h1234_5678, 0, 32'h0);
      check_result("robust_after", 1'b1, 32'h0000_0040, 32'h1234_5678, 1, 1, 1, 32'h4B);

      // Reset during the 3rd address byte.
      baud = 8'd3;
      p    = 4;
      repeat (5) @(negedge clk);
      send_byte(8'h57);
      send_byte(8'h12);
      send_byte(8'h34);
      fork
         send_byte(8'h56);
      join_none
      repeat (4 * p) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_addr tx", {31'd0, tx}, 32'd1);
      chk("rst_addr penable", {31'd0, bus.o_penable}, 32'd0);
      chk("rst_addr pwrite", {31'd0, bus.o_pwrite}, 32'd0);
      chk("rst_addr paddr", bus.o_paddr, 32'd0);
      repeat (12 * p) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // Reset while the read response is being transmitted.
      run_cmd(1'b0, 32'hCAFE_0000, 32'h0, 0, 32'hA5A5_A5A5);
      k = 0;
      while (tx !== 1'b0 && k < 2000) begin
         @(negedge clk);
         k++;
      end
      chk("rst_tx response_started", 32'(k < 2000), 32'd1);
      repeat (3 * p) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_tx tx", {31'd0, tx}, 32'd1);
      chk("rst_tx penable", {31'd0, bus.o_penable}, 32'd0);
      chk("rst_tx paddr", bus.o_paddr, 32'd0);
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (15 * p) @(negedge clk);
      xq.delete();
      lenq.delete();
      rxq.delete();
      run_cmd(1'b1, 32'h0000_2004, 32'h0000_012F, 0, 32'h0);
      check_result("rst_after", 1'b1, 32'h0000_2004, 32'h0000_012F, 1, 1, 1, 32'h4B);

      // Randomized commands against the transaction-level model.
      for (int n = 0; n < 24; n++) begin
         baud = 8'(3 + $urandom_range(0, 5));
         repeat (5) @(negedge clk);
         w  = 1'($urandom_range(0, 1));
         a  = $urandom;
         d  = $urandom;
         rd = $urandom;
         l  = ($urandom_range(0, 7) == 0) ? 300 : $urandom_range(0, 3);
         ecomp = (l + 1 <= TMO) ? 1 : 0;
         elen  = (ecomp != 0) ? l + 1 : TMO;
         if (ecomp == 0) begin
            enr = 1; eresp = 32'h45;
         end else if (w) begin
            enr = 1; eresp = 32'h4B;
         end else begin
            enr = 4; eresp = rd;
         end
         run_cmd(w, a, d, l, rd);
         check_result($sformatf("rand%0d", n), w, a, d, ecomp, elen, enr, eresp);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/uart_apb_bridge.md
# uart_apb_bridge

UART-to-register-bus bridge for the AIB top-level debug path. It deserialises host command frames from the chip's UART pin and issues single register-bus transfers (penable/pwrite/paddr/pwdata with pready/prdata) into the IO-configuration register file. It serialises write acknowledges, read data and error codes back to the host. It is the upstream feeder of the per-channel IOB config registers and is the only master on that bus.

## Interface
Parameters:
- TimeoutCyc, default 255: bus wait limit in i_clk cycles before a transfer is aborted.

Ports:
- i_clk  in  1  core clock
- i_rst_n  in  1  reset, asynchronous, active-low
- c_baud_cyc  in  8  bit period minus one, in i_clk cycles; legal range 3..255; static while traffic flows
- i_uart_rx  in  1  host-to-chip serial line, idle high, asynchronous to i_clk
- o_uart_tx  out  1  chip-to-host serial line, idle high
- o_penable  out  1  bus transfer active
- o_pwrite  out  1  1 = write, 0 = read
- o_paddr  out  32  byte address
- o_pwdata  out  32  write data
- i_pready  in  1  slave ready; a transfer completes in the cycle where o_penable & i_pready
- i_prdata  in  32  read data, valid in the completing cycle

## Operation
- RX: i_uart_rx passes through a 2-flop synchroniser. A falling edge starts a frame. The start bit is re-checked at mid-bit (count == c_baud_cyc>>1); if it reads high, the frame is a glitch and is dropped. 8 data bits are sampled LSB-first at mid-bit, followed by the stop bit. Stop = 1 raises a 1-cycle rx_valid; stop = 0 is a framing error and the byte is discarded.
- Parser FSM states are S_CMD, S_ADDR, S_WDATA, S_BUS and S_RESP.
  - S_CMD: 0x57 ('W') or 0x52 ('R') latches the direction and moves to S_ADDR; any other byte is ignored and the FSM stays in S_CMD.
  - S_ADDR: collects 4 bytes MSB-first into o_paddr. It then goes to S_WDATA for a write or to S_BUS for a read.
  - S_WDATA: collects 4 bytes MSB-first into o_pwdata, then goes to S_BUS.
  - S_BUS: o_penable=1 with o_pwrite, o_paddr and o_pwdata held stable until completion or timeout.
  - On completion: a write queues the byte 0x4B ('K'); a read captures i_prdata and queues 4 bytes MSB-first. The FSM then goes to S_RESP.
  - On timeout (TimeoutCyc cycles in S_BUS without i_pready): o_penable drops, the byte 0x45 ('E') alone is queued and the FSM goes to S_RESP.
  - S_RESP: waits until the TX queue is empty, then returns to S_CMD.
- A framing error while in S_ADDR or S_WDATA aborts the command. The FSM returns to S_CMD with no bus transfer and no response.
- Bytes received while in S_BUS or S_RESP are discarded.
- TX frame: 1 start bit (0), 8 data bits LSB-first, 1 stop bit (1). Each bit lasts c_baud_cyc+1 cycles. Queued bytes are sent back-to-back with no idle gap.
- Width rules:
  - Baud counters are 8 bits and reload to 0 at c_baud_cyc.
  - The timeout counter is $clog2(TimeoutCyc+1) bits and clears on entering S_BUS.
  - The address and data shift registers shift left by 8 bits per byte.

## Timing
- Reset values:
  - Outputs: o_uart_tx=1, o_penable=0, o_pwrite=0, o_paddr=0, o_pwdata=0.
  - Internal: FSM in S_CMD, TX queue empty, RX idle.
- RX latency: rx_valid fires 2 sync cycles + 9.5 bit periods after the falling edge of the start bit.
- o_penable rises in the cycle after rx_valid for the last address byte (read) or the last data byte (write).
- Completing cycle: o_penable & i_pready. o_penable is 0 in the following cycle. Only one transfer is issued per command, and pready is never sampled outside S_BUS.
- A write slave with pready tied high completes in 1 cycle. A read slave that raises pready on the second penable cycle completes in 2 cycles.
- The TX start bit begins in the cycle after completion or timeout.
- Asserting reset mid-frame or mid-transfer drops o_penable immediately and drives o_uart_tx high immediately; the partial command is lost.

## Test plan
- Write: c_baud_cyc=3, host sends 57 00 00 20 04 00 00 01 2F, slave pready=1 -> one 1-cycle penable with pwrite=1, paddr=0x00002004, pwdata=0x0000012F; TX returns 0x4B.
- Read: host sends 52 00 00 20 04, slave raises pready on penable cycle 2 with prdata=0x0000012F -> penable lasts 2 cycles, then TX returns 00 00 01 2F in that order.
- Timeout: read issued with pready held low -> penable deasserts after 255 cycles; TX returns the single byte 0x45; a following valid write is serviced normally.
- Robustness: host sends 0xAA, then a start-bit glitch shorter than half a bit period, then a frame with stop=0 during S_ADDR -> no penable, no TX; the next valid command works.
- Reset mid-operation: assert i_rst_n low during the 3rd address byte, then during TX of a read response -> all outputs return to their reset values immediately; a full write after reset gives 0x4B.
- Baud sweep: repeat the write test with c_baud_cyc=3, 10 and 255 -> measured TX bit period is 4, 11 and 256 cycles respectively, and the responses are correct.
